// File: rtl/window_sequencer.sv
// window_sequencer: raster-scan control for a 3x3 window built from two line FIFOs
module window_sequencer #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int LINE_DELAY = IMG_W - 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic                     win_shift,
    output logic [1:0]               fifo_wr_en,
    output logic [1:0]               fifo_rd_en,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] ctr_row,
    output logic [$clog2(IMG_W)-1:0] ctr_col,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int FW = $clog2(LINE_DELAY + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [FW-1:0] fill0, fill1;
    logic          accept, last_col, last_row, full0, full1, interior;
    assign accept     = pix_valid & pix_ready;
    assign last_col   = col == CW'(IMG_W - 1);
    assign last_row   = row == RW'(IMG_H - 1);
    assign full0      = fill0 == FW'(LINE_DELAY);
    assign full1      = fill1 == FW'(LINE_DELAY);
    assign interior   = row >= RW'(2) && col >= CW'(2);
    assign win_shift  = accept;
    assign fifo_wr_en = {2{accept}};
    assign fifo_rd_en = {accept & full1, accept & full0};
    // frame FSM with raster counters and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= RUN;
                    row       <= '0;
                    col       <= '0;
                    pix_ready <= 1'b1;
                    busy      <= 1'b1;
                end
                RUN: if (accept) begin
                    col <= last_col ? '0 : col + CW'(1);
                    row <= last_col ? (last_row ? '0 : row + RW'(1)) : row;
                    if (last_col && last_row) begin
                        state      <= DONE;
                        pix_ready  <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // line FIFO occupancy; survives frame boundaries so it stays aligned with the FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill0 <= '0;
            fill1 <= '0;
        end else begin
            fill0 <= fill0 + FW'(accept & ~full0);
            fill1 <= fill1 + FW'(accept & ~full1);
        end
    end
    // window is valid one cycle after an interior accept, matching the FIFO read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            ctr_row   <= '0;
            ctr_col   <= '0;
        end else begin
            win_valid <= accept & interior;
            if (accept & interior) begin
                ctr_row <= row - RW'(1);
                ctr_col <= col - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_window_sequencer.sv
// tb_window_sequencer: directed checks of window_sequencer on a small 8x6 image
module tb_window_sequencer;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int LD = W - 3;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_ready, win_shift, win_valid, busy, frame_done;
    logic [1:0] fifo_wr_en, fifo_rd_en;
    logic [2:0] ctr_row, ctr_col;
    int vectors = 0, miscompares = 0;
    int p = 0, g = 0, wins = 0;
    window_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .win_shift(win_shift), .fifo_wr_en(fifo_wr_en),
        .fifo_rd_en(fifo_rd_en), .win_valid(win_valid), .ctr_row(ctr_row),
        .ctr_col(ctr_col), .busy(busy), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at pixel %0d t=%0t", tag, obs, exp, p, $time);
        end
    endtask
    task automatic all_zero(input string tag);
        chk({tag, " pix_ready"}, pix_ready, 0);
        chk({tag, " win_shift"}, win_shift, 0);
        chk({tag, " wr_en"}, fifo_wr_en, 0);
        chk({tag, " rd_en"}, fifo_rd_en, 0);
        chk({tag, " win_valid"}, win_valid, 0);
        chk({tag, " ctr_row"}, ctr_row, 0);
        chk({tag, " ctr_col"}, ctr_col, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " frame_done"}, frame_done, 0);
    endtask
    task automatic px(input bit v, input bit s);
        int r, c;
        bit ev;
        @(negedge clk);
        pix_valid = v;
        start = s;
        #1;
        chk("pix_ready", pix_ready, 1);
        chk("win_shift", win_shift, v);
        chk("wr_en", fifo_wr_en, v ? 3 : 0);
        chk("rd_en", fifo_rd_en, (v && g >= LD) ? 3 : 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        r  = p / W;
        c  = p % W;
        ev = v && r >= 2 && c >= 2;
        chk("win_valid", win_valid, ev);
        if (ev) begin
            chk("ctr_row", ctr_row, r - 1);
            chk("ctr_col", ctr_col, c - 1);
            wins++;
        end
        if (v) begin
            p++;
            g++;
        end
    endtask
    task automatic begin_frame();
        @(negedge clk);
        start = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start busy", busy, 1);
        chk("start pix_ready", pix_ready, 1);
        p = 0;
        wins = 0;
    endtask
    task automatic run_frame(input bit gaps, input int start_at);
        begin_frame();
        while (p < W * H) px(gaps ? 1'($urandom_range(0, 1)) : 1'b1, p == start_at);
        chk("done frame_done", frame_done, 1);
        chk("done busy", busy, 1);
        chk("done pix_ready", pix_ready, 0);
        chk("window count", wins, (W - 2) * (H - 2));
        @(negedge clk);
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post frame_done", frame_done, 0);
        chk("post busy", busy, 0);
    endtask
    initial begin
        pix_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        all_zero("idle");
        run_frame(1'b0, -1);
        run_frame(1'b1, -1);
        run_frame(1'b0, 20);
        begin_frame();
        while (p < 3 * W + 4) px(1'b1, 1'b0);
        @(negedge clk);
        pix_valid = 1'b1;
        rst = 1'b1;
        #1;
        all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        g = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort pix_ready", pix_ready, 0);
            chk("abort frame_done", frame_done, 0);
            chk("abort win_shift", win_shift, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("start under rst busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("start under rst idle", busy, 0);
        run_frame(1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/window_sequencer.md
WINDOW_SEQUENCER -- requirements
Module: window_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 256, pixels per image row.
REQ-002 SHALL have parameter IMG_H, default 256, rows per frame.
REQ-003 SHALL have parameter LINE_DELAY, default IMG_W-3 (253), depth each line FIFO must hold before it is read.
REQ-004 SHALL have ports:
 clk  in  1  clock, rising edge.
 rst  in  1  reset, asynchronous, active-high.
 start  in  1  frame start request, single-cycle pulse.
 pix_valid  in  1  upstream pixel present.
 pix_ready  out  1  sequencer accepts a pixel this cycle.
 win_shift  out  1  shift the 3x3 window registers by one column.
 fifo_wr_en  out  2  write enables, bit0 = line FIFO 0, bit1 = line FIFO 1.
 fifo_rd_en  out  2  read enables, same bit mapping.
 win_valid  out  1  registered window holds a valid interior 3x3 neighbourhood.
 ctr_row  out  $clog2(IMG_H)  row of window centre pixel.
 ctr_col  out  $clog2(IMG_W)  column of window centre pixel.
 busy  out  1  frame in progress.
 frame_done  out  1  single-cycle end-of-frame pulse.

Function
REQ-005 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-006 IDLE: pix_ready=0; start=1 -> RUN, row and col counters cleared to 0.
REQ-007 RUN: pix_ready=1; accept = pix_valid & pix_ready.
REQ-008 On accept: win_shift=1, fifo_wr_en[0]=1, fifo_wr_en[1]=1 in the same cycle (combinational from accept).
REQ-009 Fill counters fill0/fill1 (0..LINE_DELAY) track FIFO occupancy; fifo_rd_en[n]=accept & (fillN==LINE_DELAY).
REQ-010 fillN update: write without read -> +1; write with read -> unchanged; fillN never exceeds LINE_DELAY.
REQ-011 fill0/fill1 SHALL NOT clear on start or frame end; cleared only by rst, keeping them aligned with FIFO pointers.
REQ-012 On accept, col increments; at col==IMG_W-1, col wraps to 0 and row increments.
REQ-013 Accept at row==IMG_H-1, col==IMG_W-1 -> DONE next cycle; counters wrap to 0.
REQ-014 DONE: pix_ready=0, frame_done=1 for exactly one cycle, then IDLE unconditionally.
REQ-015 busy=1 in RUN and DONE, 0 in IDLE.
REQ-016 start in RUN or DONE SHALL be ignored; start coincident with rst SHALL be ignored.
REQ-017 win_valid registered: asserted the cycle after an accept whose input row>=2 and col>=2, else 0; accounts for 1-cycle FIFO read latency.
REQ-018 With win_valid=1, ctr_row=row-1 and ctr_col=col-1 of the triggering accept, registered alongside win_valid.
REQ-019 pix_valid=0 in RUN: no shift, no FIFO enables, counters hold, win_valid=0 next cycle.
REQ-020 Frame edges (row<2 or col<2) SHALL never assert win_valid; stale FIFO data from prior frame masked by this rule.

Reset
REQ-021 rst asserted: state=IDLE, row=col=0, fill0=fill1=0, all outputs 0 (pix_ready, win_shift, fifo_wr_en, fifo_rd_en, win_valid, ctr_row, ctr_col, busy, frame_done).
REQ-022 rst mid-frame SHALL abort immediately; no frame_done generated for the aborted frame.

Verification
REQ-023 Reset then start, stream 256 pixels continuous -> fifo_rd_en[0] first high at pixel index 253, fill0 stays 253 thereafter.
REQ-024 Full 256x256 frame continuous -> win_valid count 254*254=64516; first with ctr_row=1, ctr_col=1; frame_done one pulse one cycle after last accept.
REQ-025 Random pix_valid gaps (50%) over full frame -> same 64516 windows, identical ctr sequence, no enables on idle cycles.
REQ-026 Second start after frame_done -> fill0=fill1=253 retained, rd_en asserted from first pixel, win_valid again suppressed rows 0-1.
REQ-027 rst at row 10, col 100 -> all outputs 0 next cycle, pix_ready=0 until start, no frame_done.
REQ-028 start pulsed during RUN at pixel 500 -> counters unaffected, frame completes normally.
